rr_mux_arbiter: RTL and testbench
=================================

Name: rr_mux_arbiter

Overview:
- Round-robin arbiter that shares one W-bit output path between N requesters.
- Drives an internal N:1 select and forwards the granted requester's data to a single consumer.
- Sits in front of the shared mux datapath and gives each requester exclusive ownership.
- A hold-limit timeout stops any one requester from monopolising the path.

Parameters:
N, 4, number of requesters (2..8)
W, 8, data width per requester
SEL_W, 2, width of the select index; must equal ceil(log2(N))
MAX_HOLD, 16, maximum consecutive cycles one owner may hold the grant (1..255)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
req  input  N  request vector; bit i held high while requester i wants or owns the path
data_in  input  N*W  packed data; requester i occupies bits [i*W +: W]
grant  output  N  registered one-hot grant; all zeros when idle
sel  output  SEL_W  registered index of the current owner; 0 when idle
busy  output  1  registered; high while any grant is active
data_out  output  W  data_in slice selected by sel when busy, else 0 (combinational from registered sel/busy)
expired  output  1  registered one-cycle pulse when a grant is revoked by timeout

Behaviour:
- Interface: single clock clk; reset rst is synchronous and active-high.

Reset (rst high at a clock edge):
- grant=0, sel=0, busy=0, expired=0.
- Priority pointer ptr=0; hold counter=0; state=IDLE.
- Reset takes effect mid-grant with no completion cycle.

States: IDLE, OWN.

IDLE:
- If req==0: stay in IDLE; outputs hold their idle values.
- Else: winner = first set bit of req searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
- Next edge: grant=onehot(winner), sel=winner, busy=1, hold counter=1, state=OWN.
- Latency from req rising (sampled) to grant: 1 clock.

OWN (owner o = sel):
- If req[o]==0: voluntary release.
  - Next edge: grant=0, busy=0, sel=0, ptr=(o+1) mod N, state=IDLE.
- Else if hold counter == MAX_HOLD: timeout.
  - Next edge: same as release, plus expired=1 for exactly that one cycle.
- Else: hold counter increments; grant is unchanged.
- Requests from other requesters are ignored while in OWN; there is no preemption except by timeout.

Handoff and bandwidth:
- Every release or timeout passes through exactly one IDLE cycle, so back-to-back ownership change costs 1 bubble cycle.
- Ownership window is at most MAX_HOLD cycles with grant high.

Fairness:
- The just-released owner has the lowest priority in the next arbitration.
- With all N requesting continuously, grants rotate o, o+1, ... mod N.

Boundary cases:
- N=2 with both requesting: strict alternation.
- A single requester holding req continuously for more than MAX_HOLD cycles: MAX_HOLD grant cycles, 1 IDLE cycle with expired=1, then re-granted to the same requester (it is the only request).
- ptr wraps from N-1 to 0.
- req bit dropping in the same cycle the timeout hits: counts as voluntary release, expired=0.

Invariants:
- grant is always zero or one-hot.
- grant[sel]==busy.
- data_out==0 whenever busy==0.
- Unused bits of sel (when N < 2^SEL_W) are never produced.

Test Plan:
1. rst high 2 cycles while req=4'b1111 -> grant=0, busy=0, sel=0, data_out=0; first edge after rst low gives grant=4'b0001, sel=0.
2. From idle, req=4'b0100, data_in[2]=8'hA5 -> one edge later grant=4'b0100, sel=2, data_out=8'hA5; drop req[2] -> next edge grant=0, data_out=0.
3. req=4'b1111 held, each owner drops its req after 3 owned cycles then re-raises -> grant order 0,1,2,3,0, one idle bubble between owners.
4. MAX_HOLD=16, req=4'b0010 held constantly -> grant[1] high exactly 16 cycles, then 1 cycle grant=0 with expired=1, then grant[1] again.
5. Owner 3 releases while req=4'b1001 -> next grant goes to 0 (ptr wrap), not 3.
6. Assert rst mid-OWN (cycle 5 of grant[2]) -> next edge all outputs zero; after release, req=4'b0100 is granted with ptr=0 ordering.

Source files
------------

// File: rtl/rr_mux_arbiter_if.sv
// Purpose: request/data/grant bundle between N requesters and the shared-path arbiter.
// Latency: none; wiring only.
// Backpressure: requesters hold req high until they see their grant bit, then drop it to release.
interface rr_mux_arbiter_if #(
    parameter int N     = 4,
    parameter int W     = 8,
    parameter int SEL_W = 2
);
    logic [N-1:0]     req;
    logic [N*W-1:0]   data_in;
    logic [N-1:0]     grant;
    logic [SEL_W-1:0] sel;
    logic             busy;
    logic [W-1:0]     data_out;
    logic             expired;

    // Requester side: raises requests and presents data.
    modport master (
        output req,
        output data_in,
        input  grant,
        input  sel,
        input  busy,
        input  data_out,
        input  expired
    );

    // Arbiter side: consumes requests and data, owns grant and the muxed path.
    modport slave (
        input  req,
        input  data_in,
        output grant,
        output sel,
        output busy,
        output data_out,
        output expired
    );
endinterface

// File: rtl/rr_mux_arbiter.sv
// Purpose: round-robin arbiter owning an N:1 mux; one requester at a time drives data_out.
// Latency: 1 clock from sampled req to grant; release/timeout costs one idle bubble cycle.
// Backpressure: no preemption; owner keeps the path until it drops req or hits MAX_HOLD cycles.
module rr_mux_arbiter #(
    parameter int N        = 4,
    parameter int W        = 8,
    parameter int SEL_W    = 2,
    parameter int MAX_HOLD = 16
) (
    input  logic            clk,
    input  logic            rst,
    rr_mux_arbiter_if.slave bus
);

    localparam logic [0:0]     ST_IDLE    = 1'b0;
    localparam logic [0:0]     ST_OWN     = 1'b1;
    localparam logic [7:0]     HOLD_LIMIT = 8'(MAX_HOLD);
    // One extra bit so ptr + offset never overflows before the modulo-N fold.
    localparam logic [SEL_W:0] N_EXT      = (SEL_W + 1)'(N);
    localparam logic [N-1:0]   ONE_HOT0   = {{(N - 1){1'b0}}, 1'b1};

    // Registered state
    logic [0:0]       state_q;
    logic [SEL_W-1:0] ptr_q;
    logic [7:0]       hold_q;
    logic [N-1:0]     grant_q;
    logic [SEL_W-1:0] sel_q;
    logic             busy_q;
    logic             expired_q;

    // Next-state values
    logic [0:0]       state_d;
    logic [SEL_W-1:0] ptr_d;
    logic [7:0]       hold_d;
    logic [N-1:0]     grant_d;
    logic [SEL_W-1:0] sel_d;
    logic             busy_d;
    logic             expired_d;

    // Arbitration helpers
    logic             win_vld;
    logic [SEL_W-1:0] win_idx;
    logic [SEL_W:0]   cand;
    logic             owner_req;
    logic             hold_hit;
    logic [SEL_W-1:0] next_ptr;

    // Rotating priority search: first request at or after ptr, wrapping mod N.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int k = 0; k < N; k++) begin
            cand = {1'b0, ptr_q} + (SEL_W + 1)'(k);
            if (cand >= N_EXT) begin
                cand = cand - N_EXT;
            end
            if (!win_vld && bus.req[cand[SEL_W-1:0]]) begin
                win_vld = 1'b1;
                win_idx = cand[SEL_W-1:0];
            end
        end
    end

    // Owner status and the post-release pointer (owner moves to lowest priority).
    always_comb begin
        owner_req = bus.req[sel_q];
        hold_hit  = (hold_q == HOLD_LIMIT);
        if ({1'b0, sel_q} == N_EXT - 1'b1) begin
            next_ptr = '0;
        end else begin
            next_ptr = sel_q + 1'b1;
        end
    end

    // IDLE/OWN transition logic; release and timeout both pass through IDLE.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        grant_d   = grant_q;
        sel_d     = sel_q;
        busy_d    = busy_q;
        expired_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (win_vld) begin
                    grant_d = ONE_HOT0 << win_idx;
                    sel_d   = win_idx;
                    busy_d  = 1'b1;
                    hold_d  = 8'd1;
                    state_d = ST_OWN;
                end else begin
                    grant_d = '0;
                    sel_d   = '0;
                    busy_d  = 1'b0;
                    hold_d  = '0;
                end
            end
            ST_OWN: begin
                if (!owner_req || hold_hit) begin
                    // A dropped req wins over a same-cycle timeout: no expired pulse.
                    grant_d   = '0;
                    sel_d     = '0;
                    busy_d    = 1'b0;
                    hold_d    = '0;
                    ptr_d     = next_ptr;
                    state_d   = ST_IDLE;
                    expired_d = owner_req;
                end else begin
                    hold_d = hold_q + 8'd1;
                end
            end
            default: begin
                grant_d = '0;
                sel_d   = '0;
                busy_d  = 1'b0;
                hold_d  = '0;
                ptr_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any grant immediately.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            hold_q    <= '0;
            grant_q   <= '0;
            sel_q     <= '0;
            busy_q    <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            grant_q   <= grant_d;
            sel_q     <= sel_d;
            busy_q    <= busy_d;
            expired_q <= expired_d;
        end
    end

    // Shared datapath mux, forced to zero while nobody owns the path.
    always_comb begin
        bus.data_out = '0;
        if (busy_q) begin
            bus.data_out = bus.data_in[int'(sel_q) * W +: W];
        end
    end

    assign bus.grant   = grant_q;
    assign bus.sel     = sel_q;
    assign bus.busy    = busy_q;
    assign bus.expired = expired_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Purpose: directed scoreboard bench for rr_mux_arbiter (N=4, W=8, MAX_HOLD=16).
// Latency: expects grant one clock after a sampled request.
// Backpressure: bench drives req on the falling edge and checks outputs on the next falling edge.
module tb_rr_mux_arbiter;

    typedef struct packed {
        logic [3:0] g;
        logic [1:0] s;
        logic       b;
        logic [7:0] d;
        logic       e;
    } obs_t;

    logic clk;
    logic rst;
    int   tests;
    int   fails;
    obs_t exp_q[$];
    string tag_q[$];
    logic [7:0] dat_tbl [4];

    rr_mux_arbiter_if #(.N(4), .W(8), .SEL_W(2)) bus ();

    rr_mux_arbiter #(.N(4), .W(8), .SEL_W(2), .MAX_HOLD(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive req, queue the expected outputs after the next edge, then pop and compare.
    task automatic step(input logic [3:0] r, input int owner, input logic exp_e, input string tag);
        obs_t  ex;
        obs_t  ob;
        string t;
        ex = '0;
        if (owner >= 0) begin
            ex.g = 4'(1 << owner);
            ex.s = 2'(owner);
            ex.b = 1'b1;
            ex.d = dat_tbl[owner];
        end
        ex.e = exp_e;
        bus.req = r;
        exp_q.push_back(ex);
        tag_q.push_back(tag);
        @(negedge clk);
        ob = {bus.grant, bus.sel, bus.busy, bus.data_out, bus.expired};
        ex = exp_q.pop_front();
        t  = tag_q.pop_front();
        tests++;
        assert (ob === ex) else begin
            fails++;
            $error("FAIL %s: observed grant=%b sel=%0d busy=%b data=%h exp=%b, expected grant=%b sel=%0d busy=%b data=%h exp=%b",
                   t, ob.g, ob.s, ob.b, ob.d, ob.e, ex.g, ex.s, ex.b, ex.d, ex.e);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
        $fatal(1, "watchdog expired");
    end

    initial begin
        tests = 0;
        fails = 0;
        dat_tbl[0] = 8'h11;
        dat_tbl[1] = 8'h22;
        dat_tbl[2] = 8'hA5;
        dat_tbl[3] = 8'h44;
        bus.data_in = {dat_tbl[3], dat_tbl[2], dat_tbl[1], dat_tbl[0]};
        bus.req = '0;

        // Reset held with all requesting: outputs stay idle.
        rst = 1'b1;
        step(4'hF, -1, 1'b0, "rst_cyc0");
        step(4'hF, -1, 1'b0, "rst_cyc1");
        rst = 1'b0;
        step(4'hF, 0, 1'b0, "first_grant_0");

        // Full rotation, each owner keeps 3 cycles then drops once.
        step(4'hF, 0, 1'b0, "own0_c2");
        step(4'hF, 0, 1'b0, "own0_c3");
        step(4'hE, -1, 1'b0, "bubble_0_1");
        for (int i = 0; i < 3; i++) step(4'hF, 1, 1'b0, "own1");
        step(4'hD, -1, 1'b0, "bubble_1_2");
        for (int i = 0; i < 3; i++) step(4'hF, 2, 1'b0, "own2");
        step(4'hB, -1, 1'b0, "bubble_2_3");
        for (int i = 0; i < 3; i++) step(4'hF, 3, 1'b0, "own3");
        step(4'h7, -1, 1'b0, "bubble_3_0");
        step(4'hF, 0, 1'b0, "rotate_back_0");
        step(4'h0, -1, 1'b0, "release_0");
        step(4'h0, -1, 1'b0, "idle_stays");

        // Single requester 2, data forwarded then zeroed on release.
        step(4'h4, 2, 1'b0, "single_req2");
        step(4'h0, -1, 1'b0, "release_2");

        // Owner 3 releases while 0 waits: pointer wraps to 0.
        step(4'h8, 3, 1'b0, "own3_wrap");
        step(4'h9, 3, 1'b0, "own3_no_preempt");
        step(4'h1, -1, 1'b0, "release_3");
        step(4'h9, 0, 1'b0, "wrap_to_0");
        step(4'h0, -1, 1'b0, "release_0b");

        // Continuous single requester: 16 grant cycles, timeout pulse, regrant.
        for (int i = 0; i < 16; i++) step(4'h2, 1, 1'b0, "hold1");
        step(4'h2, -1, 1'b1, "timeout_expired");
        step(4'h2, 1, 1'b0, "regrant_1");
        for (int i = 0; i < 15; i++) step(4'h2, 1, 1'b0, "hold1_again");
        // Drop on the timeout cycle counts as voluntary release.
        step(4'h0, -1, 1'b0, "drop_at_timeout");
        step(4'h0, -1, 1'b0, "idle_after_drop");

        // Reset during the fifth owned cycle of requester 2.
        for (int i = 0; i < 5; i++) step(4'h4, 2, 1'b0, "own2_pre_rst");
        rst = 1'b1;
        step(4'h4, -1, 1'b0, "rst_mid_own");
        rst = 1'b0;
        // ptr back at 0: 1 beats 3 (a stale ptr of 2 would pick 3).
        step(4'hA, 1, 1'b0, "ptr0_after_rst");
        step(4'h0, -1, 1'b0, "release_1");
        step(4'h4, 2, 1'b0, "req2_after_rst");
        step(4'h0, -1, 1'b0, "release_2b");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
